// File: rtl/alu_seq.sv
// Sequential ALU: operands are captured on start, most ops finish in one
// EXEC cycle, MUL runs as a WIDTH-cycle shift-add, and a one-cycle DONE state
// raises the done pulse before the unit returns to IDLE.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] inA,
    input  logic [WIDTH-1:0] inB,
    output logic [WIDTH-1:0] ans,
    output logic [WIDTH-1:0] ans_hi,
    output logic [1:0]       flags,
    output logic             busy,
    output logic             done
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] LAST_STEP = SW'(WIDTH - 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SLL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } stateT;

    stateT              state;
    logic [2:0]         opReg;
    logic [WIDTH-1:0]   aReg;
    logic [WIDTH-1:0]   bReg;
    logic [WIDTH-1:0]   prodHi;
    logic [WIDTH-1:0]   prodLo;
    logic [SW-1:0]      count;

    logic [SW-1:0]      shAmt;
    logic [WIDTH:0]     addSum;
    logic [WIDTH:0]     subDiff;
    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] mulNext;
    logic [WIDTH-1:0]   aluRes;
    logic               aluCarry;

    // Single-cycle datapath on the latched operands, plus one shift-add step
    // of the multiplier: prodLo starts as B and is consumed LSB first while
    // partial sums accumulate into prodHi.
    always_comb begin
        shAmt    = bReg[SW-1:0];
        addSum   = {1'b0, aReg} + {1'b0, bReg};
        subDiff  = {1'b0, aReg} - {1'b0, bReg};
        mulSum   = {1'b0, prodHi} + (prodLo[0] ? {1'b0, aReg} : {(WIDTH+1){1'b0}});
        mulNext  = {mulSum, prodLo[WIDTH-1:1]};
        aluRes   = '0;
        aluCarry = 1'b0;
        case (opReg)
            OP_ADD: begin
                aluRes   = addSum[WIDTH-1:0];
                aluCarry = addSum[WIDTH];
            end
            OP_SUB: begin
                aluRes   = subDiff[WIDTH-1:0];
                aluCarry = subDiff[WIDTH];
            end
            OP_AND: aluRes = aReg & bReg;
            OP_OR:  aluRes = aReg | bReg;
            OP_SLT: aluRes = {{(WIDTH-1){1'b0}}, ($signed(aReg) < $signed(bReg))};
            OP_SLL: aluRes = aReg << shAmt;
            OP_SRA: aluRes = $signed(aReg) >>> shAmt;
            default: aluRes = '0;
        endcase
    end

    // Control FSM with registered results; outputs change only on the write edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            opReg  <= '0;
            aReg   <= '0;
            bReg   <= '0;
            prodHi <= '0;
            prodLo <= '0;
            count  <= '0;
            ans    <= '0;
            ans_hi <= '0;
            flags  <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        opReg  <= op;
                        aReg   <= inA;
                        bReg   <= inB;
                        prodHi <= '0;
                        prodLo <= inB;
                        count  <= '0;
                        busy   <= 1'b1;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    if (opReg == OP_MUL) begin
                        prodHi <= mulNext[2*WIDTH-1:WIDTH];
                        prodLo <= mulNext[WIDTH-1:0];
                        if (count == LAST_STEP) begin
                            ans    <= mulNext[WIDTH-1:0];
                            ans_hi <= mulNext[2*WIDTH-1:WIDTH];
                            flags  <= {(mulNext == '0), 1'b0};
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end else begin
                        ans    <= aluRes;
                        ans_hi <= '0;
                        flags  <= {(aluRes == '0), aluCarry};
                        done   <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    count <= '0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq at WIDTH=8 with hand-computed expectations.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] op;
    logic [7:0] inA;
    logic [7:0] inB;
    logic [7:0] ans;
    logic [7:0] ans_hi;
    logic [1:0] flags;
    logic       busy;
    logic       done;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    int doneCount  = 0;
    int busyCycles = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .inA    (inA),
        .inB    (inB),
        .ans    (ans),
        .ans_hi (ans_hi),
        .flags  (flags),
        .busy   (busy),
        .done   (done)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    // Count done pulses and busy cycles as seen at each rising edge
    always @(posedge clk) begin
        if (done) doneCount++;
        if (busy) busyCycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResult(input string tag, input logic [7:0] expAns,
                               input logic [7:0] expHi, input logic [1:0] expFlags);
        checkOutput({tag, "/ans"}, 32'(ans), 32'(expAns));
        checkOutput({tag, "/ans_hi"}, 32'(ans_hi), 32'(expHi));
        checkOutput({tag, "/flags"}, 32'(flags), 32'(expFlags));
    endtask

    // Issue one op at a negedge, then scramble the inputs after E0
    task automatic applyStimulus(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        op    = o;
        inA   = a;
        inB   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        op    = ~o;
        inA   = ~a;
        inB   = ~b;
    endtask

    // Wait (bounded) for done, checking latency in negedges after E0
    task automatic waitDone(input string tag, input int expLat);
        int n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "/latency"}, 32'(n), 32'(expLat));
    endtask

    // After the DONE cycle the unit must be idle with done dropped
    task automatic finishOp(input string tag);
        @(negedge clk);
        checkOutput({tag, "/doneLow"}, 32'(done), 32'd0);
        checkOutput({tag, "/busyLow"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        inA   = 8'h00;
        inB   = 8'h00;
        repeat (2) @(negedge clk);
        checkResult("reset", 8'h00, 8'h00, 2'b00);
        checkOutput("reset/busy", 32'(busy), 32'd0);
        checkOutput("reset/done", 32'(done), 32'd0);
        reset = 1'b0;

        // ADD with carry-out
        doneCount = 0;
        applyStimulus(3'b000, 8'hF0, 8'h20);
        waitDone("add", 1);
        checkResult("add", 8'h10, 8'h00, 2'b01);
        checkOutput("add/busyInDone", 32'(busy), 32'd1);
        finishOp("add");
        checkOutput("add/donePulses", 32'(doneCount), 32'd1);

        // SUB with borrow, then SUB to zero
        applyStimulus(3'b001, 8'h02, 8'h0E);
        waitDone("subBorrow", 1);
        checkResult("subBorrow", 8'hF4, 8'h00, 2'b01);
        finishOp("subBorrow");
        applyStimulus(3'b001, 8'h0E, 8'h0E);
        waitDone("subZero", 1);
        checkResult("subZero", 8'h00, 8'h00, 2'b10);
        finishOp("subZero");

        // ADD wrapping to zero sets both flags
        applyStimulus(3'b000, 8'hFF, 8'h01);
        waitDone("addWrap", 1);
        checkResult("addWrap", 8'h00, 8'h00, 2'b11);
        finishOp("addWrap");

        // Logic ops
        applyStimulus(3'b010, 8'hF0, 8'h0F);
        waitDone("and", 1);
        checkResult("and", 8'h00, 8'h00, 2'b10);
        finishOp("and");
        applyStimulus(3'b011, 8'hA0, 8'h05);
        waitDone("or", 1);
        checkResult("or", 8'hA5, 8'h00, 2'b00);
        finishOp("or");

        // MUL 0xFF*0xFF: 8 EXEC cycles, 9 busy cycles
        doneCount  = 0;
        busyCycles = 0;
        applyStimulus(3'b100, 8'hFF, 8'hFF);
        waitDone("mulMax", 8);
        checkResult("mulMax", 8'h01, 8'hFE, 2'b00);
        finishOp("mulMax");
        checkOutput("mulMax/busyCycles", 32'(busyCycles), 32'd9);
        checkOutput("mulMax/donePulses", 32'(doneCount), 32'd1);

        // MUL 0x0D*0x0B
        applyStimulus(3'b100, 8'h0D, 8'h0B);
        waitDone("mulSmall", 8);
        checkResult("mulSmall", 8'h8F, 8'h00, 2'b00);
        finishOp("mulSmall");
        repeat (2) @(negedge clk);
        checkOutput("mulSmall/hold", 32'(ans), 32'h8F);

        // Shifts: only low 3 bits of inB are the amount
        applyStimulus(3'b111, 8'h80, 8'hF3);
        waitDone("sra", 1);
        checkResult("sra", 8'hF0, 8'h00, 2'b00);
        finishOp("sra");
        applyStimulus(3'b110, 8'h81, 8'h09);
        waitDone("sll", 1);
        checkResult("sll", 8'h02, 8'h00, 2'b00);
        finishOp("sll");
        applyStimulus(3'b111, 8'h5A, 8'h08);
        waitDone("sraZero", 1);
        checkResult("sraZero", 8'h5A, 8'h00, 2'b00);
        finishOp("sraZero");

        // Signed compare
        applyStimulus(3'b101, 8'h80, 8'h01);
        waitDone("sltTrue", 1);
        checkResult("sltTrue", 8'h01, 8'h00, 2'b00);
        finishOp("sltTrue");
        applyStimulus(3'b101, 8'h01, 8'h80);
        waitDone("sltFalse", 1);
        checkResult("sltFalse", 8'h00, 8'h00, 2'b10);
        finishOp("sltFalse");

        // Start pulsed as ADD throughout a MUL and its DONE cycle is ignored
        doneCount = 0;
        applyStimulus(3'b100, 8'h12, 8'h34);
        repeat (8) begin
            start = 1'b1;
            op    = 3'b000;
            inA   = 8'h01;
            inB   = 8'h01;
            @(negedge clk);
        end
        checkOutput("ignore/doneAtE8", 32'(done), 32'd1);
        checkResult("ignore", 8'hA8, 8'h03, 2'b00);
        @(negedge clk);
        start = 1'b0;
        checkOutput("ignore/busyAfterDone", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("ignore/noRestart", 32'(busy), 32'd0);
        checkOutput("ignore/donePulses", 32'(doneCount), 32'd1);
        checkOutput("ignore/ansKept", 32'(ans), 32'hA8);

        // Reset right after E4 of a MUL discards it
        doneCount = 0;
        applyStimulus(3'b100, 8'hFF, 8'hFF);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkResult("midReset", 8'h00, 8'h00, 2'b00);
        checkOutput("midReset/busy", 32'(busy), 32'd0);
        checkOutput("midReset/done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        checkOutput("midReset/held", 32'(ans_hi), 32'd0);
        reset = 1'b0;
        op    = 3'b000;
        inA   = 8'h01;
        inB   = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone("postReset", 1);
        checkResult("postReset", 8'h02, 8'h00, 2'b00);
        finishOp("postReset");
        checkOutput("postReset/donePulses", 32'(doneCount), 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
